// File: rtl/link_train_pkg.sv
// link_train_pkg: state encodings and LED source selection shared by the link training controller
package link_train_pkg;
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HOLDOFF = 3'd1,
    ST_TRAIN   = 3'd2,
    ST_BACKOFF = 3'd3,
    ST_LINKED  = 3'd4,
    ST_FAILED  = 3'd5
  } state_e;
  typedef enum logic [1:0] {LED_OFF, LED_ON, LED_SLOW, LED_FAST} led_sel_e;
  function automatic led_sel_e led_sel(state_e s);
    return s == ST_IDLE ? LED_OFF : s == ST_LINKED ? LED_ON : s == ST_FAILED ? LED_FAST : LED_SLOW;
  endfunction
endpackage

// File: rtl/link_debounce.sv
// link_debounce: flags the DEB_CYC-th consecutive cycle of in_i matching pol_i
module link_debounce #(
  parameter int DEB_CYC = 4
) (
  input  logic core_clk,
  input  logic core_rst,
  input  logic clr_i,
  input  logic pol_i,
  input  logic in_i,
  output logic done_o
);
  localparam int CW = $clog2(DEB_CYC + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic match;
  always_comb begin
    match  = in_i == pol_i;
    done_o = match && cnt_q == CW'(DEB_CYC - 1);
    cnt_d  = (clr_i || !match || done_o) ? '0 : cnt_q + CW'(1);
  end
  always_ff @(posedge core_clk) begin
    if (core_rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/link_train_ctrl.sv
// link_train_ctrl: PCIe LTSSM enable sequencing with holdoff, timeout, bounded retry and drop detection
module link_train_ctrl
  import link_train_pkg::*;
#(
  parameter int HOLDOFF_CYC  = 1024,
  parameter int TRAIN_TO_CYC = 1048576,
  parameter int MAX_RETRY    = 3,
  parameter int DEB_CYC      = 4,
  parameter int LED_DIV_W    = 24
) (
  input  logic       core_clk,
  input  logic       core_rst,
  input  logic       cfg_enable_i,
  input  logic       link_up_i,
  output logic       app_ltssm_enable_o,
  output logic       link_ok_o,
  output logic       link_fail_o,
  output logic [2:0] state_o,
  output logic [3:0] retry_cnt_o,
  output logic [7:0] drop_cnt_o,
  output logic       core_clk_led_o
);
  localparam int T_MAX = HOLDOFF_CYC > TRAIN_TO_CYC ? HOLDOFF_CYC : TRAIN_TO_CYC;
  localparam int TW = T_MAX < 2 ? 1 : $clog2(T_MAX);
  state_e state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [3:0] retry_q, retry_d;
  logic [7:0] drop_q, drop_d;
  logic [LED_DIV_W-1:0] div_q, div_d;
  logic ltssm_q, ok_q, fail_q, led_q, led_d;
  logic deb_done, deb_clr, hold_done, train_to;
  led_sel_e sel;
  // LINKED watches for sustained low, every other state for sustained high
  link_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
    .core_clk(core_clk),
    .core_rst(core_rst),
    .clr_i(deb_clr),
    .pol_i(state_q != ST_LINKED),
    .in_i(link_up_i),
    .done_o(deb_done)
  );
  always_comb begin
    hold_done = tmr_q == TW'(HOLDOFF_CYC - 1);
    train_to  = tmr_q == TW'(TRAIN_TO_CYC - 1);
    state_d   = state_q;
    retry_d   = retry_q;
    drop_d    = drop_q;
    if (!cfg_enable_i) begin
      state_d = ST_IDLE;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_HOLDOFF;
        ST_HOLDOFF, ST_BACKOFF: state_d = hold_done ? ST_TRAIN : state_q;
        ST_TRAIN: begin
          if (deb_done) begin
            state_d = ST_LINKED;
            retry_d = '0;
          end else if (train_to) begin
            state_d = retry_q == 4'(MAX_RETRY) ? ST_FAILED : ST_BACKOFF;
            retry_d = retry_q == 4'(MAX_RETRY) ? retry_q : retry_q + 4'd1;
          end
        end
        ST_LINKED: begin
          state_d = deb_done ? ST_BACKOFF : ST_LINKED;
          drop_d  = drop_q + 8'(deb_done && drop_q != 8'hff);
        end
        default: state_d = state_q;
      endcase
    end
    deb_clr = state_d != state_q;
    tmr_d   = deb_clr ? '0 : tmr_q + TW'(tmr_q != TW'(T_MAX - 1));
    div_d   = div_q + LED_DIV_W'(1);
    sel     = led_sel(state_d);
    led_d   = sel == LED_ON || (sel == LED_SLOW && div_d[LED_DIV_W-1]) ||
              (sel == LED_FAST && div_d[LED_DIV_W-3]);
  end
  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      retry_q <= '0;
      drop_q  <= '0;
      div_q   <= '0;
      ltssm_q <= 1'b0;
      ok_q    <= 1'b0;
      fail_q  <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      retry_q <= retry_d;
      drop_q  <= drop_d;
      div_q   <= div_d;
      ltssm_q <= state_d == ST_TRAIN || state_d == ST_LINKED;
      ok_q    <= state_d == ST_LINKED;
      fail_q  <= state_d == ST_FAILED;
      led_q   <= led_d;
    end
  end
  assign app_ltssm_enable_o = ltssm_q;
  assign link_ok_o          = ok_q;
  assign link_fail_o        = fail_q;
  assign state_o            = state_q;
  assign retry_cnt_o        = retry_q;
  assign drop_cnt_o         = drop_q;
  assign core_clk_led_o     = led_q;
endmodule

// File: tb/tb_link_train_ctrl.sv
// tb_link_train_ctrl: directed scenario checks of link_train_ctrl with short phase lengths
module tb_link_train_ctrl;
  logic clk = 1'b0, rst = 1'b1, cfg = 1'b0, link = 1'b0;
  logic ltssm, ok, fail, led;
  logic [2:0] state;
  logic [3:0] retry;
  logic [7:0] drop;
  int chk = 0, pass = 0;

  link_train_ctrl #(
    .HOLDOFF_CYC(8), .TRAIN_TO_CYC(32), .MAX_RETRY(2), .DEB_CYC(4), .LED_DIV_W(6)
  ) dut (
    .core_clk(clk), .core_rst(rst), .cfg_enable_i(cfg), .link_up_i(link),
    .app_ltssm_enable_o(ltssm), .link_ok_o(ok), .link_fail_o(fail), .state_o(state),
    .retry_cnt_o(retry), .drop_cnt_o(drop), .core_clk_led_o(led)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_train();
    int n = 0;
    while (state !== 3'd2 && n < 40) begin step(1); n++; end
    chk++; if (n >= 40) $display("FAIL wait_train: state %0d never reached 2", state); else pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg = 1'b0; link = 1'b0;
    step(2);
    chk++; if (state !== 3'd0) $display("FAIL reset_state: got %0d expected 0", state); else pass++;
    chk++; if ({ltssm, ok, fail, led} !== 4'b0) $display("FAIL reset_flags: got %b expected 0000", {ltssm, ok, fail, led}); else pass++;
    chk++; if ({retry, drop} !== 12'd0) $display("FAIL reset_counts: got retry %0d drop %0d expected 0 0", retry, drop); else pass++;
    rst = 1'b0;
  endtask

  task automatic test_bringup();
    int cyc = 0, bad = 0;
    cfg = 1'b1;
    while (ltssm !== 1'b1 && cyc < 30) begin
      step(1); cyc++;
      if (cyc == 1) begin
        chk++; if (state !== 3'd1) $display("FAIL holdoff_entry: got %0d expected 1", state); else pass++;
      end
    end
    chk++; if (cyc != 9) $display("FAIL ltssm_rise: got cycle %0d expected 9", cyc); else pass++;
    chk++; if (state !== 3'd2) $display("FAIL train_state: got %0d expected 2", state); else pass++;
    step(5);
    link = 1'b1;
    cyc = 0;
    while (ok !== 1'b1 && cyc < 20) begin step(1); cyc++; end
    chk++; if (cyc != 4) $display("FAIL link_ok_delay: got %0d expected 4", cyc); else pass++;
    chk++; if (state !== 3'd4 || ltssm !== 1'b1 || retry !== 4'd0) $display("FAIL linked: got state %0d ltssm %b retry %0d expected 4 1 0", state, ltssm, retry); else pass++;
    repeat (16) begin
      if (led !== 1'b1) bad++;
      step(1);
    end
    chk++; if (bad != 0) $display("FAIL led_linked: got %0d low cycles expected 0", bad); else pass++;
  endtask

  task automatic test_glitch_drop();
    link = 1'b0; step(3); link = 1'b1; step(2);
    chk++; if (state !== 3'd4 || ok !== 1'b1) $display("FAIL glitch_ignored: got state %0d ok %b expected 4 1", state, ok); else pass++;
    link = 1'b0; step(3);
    chk++; if (state !== 3'd4) $display("FAIL drop_early: got %0d expected 4", state); else pass++;
    step(1);
    chk++; if (state !== 3'd3 || ok !== 1'b0 || ltssm !== 1'b0) $display("FAIL drop_backoff: got state %0d ok %b ltssm %b expected 3 0 0", state, ok, ltssm); else pass++;
    chk++; if (drop !== 8'd1) $display("FAIL drop_cnt: got %0d expected 1", drop); else pass++;
    step(3);
    cfg = 1'b0; step(1);
    chk++; if (state !== 3'd0 || {ltssm, ok, fail, led} !== 4'b0 || retry !== 4'd0) $display("FAIL backoff_abort: got state %0d flags %b retry %0d expected 0 0000 0", state, {ltssm, ok, fail, led}, retry); else pass++;
  endtask

  task automatic test_retry_fail();
    int cyc = 0, att = 0;
    logic [3:0] rv [3];
    logic [2:0] prev;
    rst = 1'b1; step(1); rst = 1'b0;
    cfg = 1'b1; link = 1'b0;
    prev = state;
    rv[0] = 4'hf; rv[1] = 4'hf; rv[2] = 4'hf;
    while (fail !== 1'b1 && cyc < 300) begin
      step(1); cyc++;
      if (state === 3'd2 && prev !== 3'd2) begin
        if (att < 3) rv[att] = retry;
        att++;
      end
      prev = state;
    end
    chk++; if (cyc != 121) $display("FAIL fail_time: got cycle %0d expected 121", cyc); else pass++;
    chk++; if (att != 3) $display("FAIL attempts: got %0d expected 3", att); else pass++;
    chk++; if (rv[0] !== 4'd0) $display("FAIL retry_a0: got %0d expected 0", rv[0]); else pass++;
    chk++; if (rv[1] !== 4'd1) $display("FAIL retry_a1: got %0d expected 1", rv[1]); else pass++;
    chk++; if (rv[2] !== 4'd2) $display("FAIL retry_a2: got %0d expected 2", rv[2]); else pass++;
    chk++; if (state !== 3'd5 || ltssm !== 1'b0 || retry !== 4'd2) $display("FAIL failed_state: got state %0d ltssm %b retry %0d expected 5 0 2", state, ltssm, retry); else pass++;
  endtask

  task automatic test_led_failed();
    int n = 0, bad = 0;
    logic cur;
    cur = led;
    while (led === cur && n < 16) begin step(1); n++; end
    chk++; if (n >= 16) $display("FAIL led_fail_toggle: got no toggle expected toggle within 16"); else pass++;
    cur = led;
    repeat (3) begin
      repeat (7) begin step(1); if (led !== cur) bad++; end
      step(1);
      if (led === cur) bad++;
      cur = led;
    end
    chk++; if (bad != 0) $display("FAIL led_fail_period: got %0d errors expected 0", bad); else pass++;
    chk++; if (state !== 3'd5 || fail !== 1'b1) $display("FAIL failed_hold: got state %0d fail %b expected 5 1", state, fail); else pass++;
    cfg = 1'b0; step(1);
    chk++; if (state !== 3'd0 || {fail, led, retry} !== 6'd0) $display("FAIL failed_exit: got state %0d fail %b led %b retry %0d expected 0 0 0 0", state, fail, led, retry); else pass++;
  endtask

  task automatic test_race();
    rst = 1'b1; step(1); rst = 1'b0;
    cfg = 1'b1; link = 1'b0;
    wait_train();
    step(28);
    link = 1'b1;
    step(3);
    chk++; if (state !== 3'd2) $display("FAIL race_pre: got %0d expected 2", state); else pass++;
    step(1);
    chk++; if (state !== 3'd4 || ok !== 1'b1 || retry !== 4'd0) $display("FAIL race_linked: got state %0d ok %b retry %0d expected 4 1 0", state, ok, retry); else pass++;
  endtask

  task automatic test_reset_mid_train();
    rst = 1'b1; step(1); rst = 1'b0;
    cfg = 1'b1; link = 1'b0;
    wait_train();
    step(5);
    rst = 1'b1; step(1);
    chk++; if (state !== 3'd0 || {ltssm, ok, fail, led} !== 4'b0 || {retry, drop} !== 12'd0) $display("FAIL rst_mid_train: got state %0d flags %b retry %0d drop %0d expected 0 0000 0 0", state, {ltssm, ok, fail, led}, retry, drop); else pass++;
    rst = 1'b0; step(1);
    chk++; if (state !== 3'd1) $display("FAIL rst_restart: got %0d expected 1", state); else pass++;
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_glitch_drop();
    test_retry_fail();
    test_led_failed();
    test_race();
    test_reset_mid_train();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end
endmodule

// File: doc/link_train_ctrl.md
LINK_TRAIN_CTRL -- requirements
Module: link_train_ctrl

Interface
REQ-001 Parameter HOLDOFF_CYC, default 1024, SHALL set the cycles LTSSM is held disabled before each training attempt.
REQ-002 Parameter TRAIN_TO_CYC, default 1048576, SHALL set the training timeout in cycles.
REQ-003 Parameter MAX_RETRY, default 3, SHALL set the retries allowed after the first attempt before FAILED.
REQ-004 Parameter DEB_CYC, default 4, SHALL set the link_up debounce length in cycles.
REQ-005 Parameter LED_DIV_W, default 24, SHALL set the LED divider counter width.
REQ-006 core_clk, input, 1, SHALL be the single clock.
REQ-007 core_rst, input, 1, SHALL be the synchronous active-high reset.
REQ-008 cfg_enable_i, input, 1, SHALL request link bring-up while high.
REQ-009 link_up_i, input, 1, SHALL be the PCIe core link-up indication, already synchronous to core_clk.
REQ-010 app_ltssm_enable_o, output, 1, SHALL drive the PCIe core LTSSM enable.
REQ-011 link_ok_o, output, 1, SHALL indicate a debounced link is up.
REQ-012 link_fail_o, output, 1, SHALL indicate retries are exhausted.
REQ-013 state_o, output, 3, SHALL expose the current state encoding.
REQ-014 retry_cnt_o, output, 4, SHALL expose retries used in the current bring-up.
REQ-015 drop_cnt_o, output, 8, SHALL count link drops from LINKED, saturating at 255.
REQ-016 core_clk_led_o, output, 1, SHALL drive the status LED.

Function
REQ-017 The FSM SHALL have states IDLE=0, HOLDOFF=1, TRAIN=2, BACKOFF=3, LINKED=4, FAILED=5.
REQ-018 cfg_enable_i low, sampled in any state, SHALL force IDLE the next cycle and clear retry_cnt; this has priority over every other transition.
REQ-019 IDLE SHALL move to HOLDOFF on the first cycle cfg_enable_i is sampled high, with the phase timer cleared.
REQ-020 HOLDOFF and BACKOFF SHALL each last exactly HOLDOFF_CYC cycles, then enter TRAIN with the timer cleared.
REQ-021 In TRAIN, DEB_CYC consecutive cycles of link_up_i high SHALL enter LINKED and clear retry_cnt.
REQ-022 In TRAIN, after TRAIN_TO_CYC cycles without entering LINKED, the FSM SHALL go to FAILED if retry_cnt==MAX_RETRY; otherwise it SHALL increment retry_cnt and go to BACKOFF.
REQ-023 If debounce completion and timeout occur in the same cycle, LINKED SHALL win.
REQ-024 In LINKED, DEB_CYC consecutive cycles of link_up_i low SHALL enter BACKOFF and increment drop_cnt (saturating); shorter low glitches SHALL be ignored.
REQ-025 FAILED SHALL hold until cfg_enable_i is low.
REQ-026 app_ltssm_enable_o SHALL be 1 exactly in the cycles where state_o is TRAIN or LINKED.
REQ-027 link_ok_o SHALL be 1 exactly in LINKED; link_fail_o SHALL be 1 exactly in FAILED.
REQ-028 A free-running LED_DIV_W-bit counter SHALL drive core_clk_led_o as follows: 0 in IDLE; counter MSB in HOLDOFF, TRAIN and BACKOFF; 1 in LINKED; counter bit LED_DIV_W-3 in FAILED.
REQ-029 All outputs SHALL be registered.
REQ-030 The phase timer SHALL be sized to max(HOLDOFF_CYC, TRAIN_TO_CYC) and SHALL NOT wrap within a phase.

Reset
REQ-031 Reset SHALL set state to IDLE, clear all counters and timers, drive all outputs to 0, and abort any phase in progress on the next edge.

Structure
REQ-032 State encodings and LED-select constants SHALL live in the shared package link_train_pkg.
REQ-033 The debounce SHALL be the sub-module link_debounce, parameterized by DEB_CYC, with a polarity-select input and a clear input.

Verification (HOLDOFF_CYC=8, TRAIN_TO_CYC=32, MAX_RETRY=2, DEB_CYC=4, LED_DIV_W=6)
REQ-034 Raise cfg_enable_i at cycle 0 and raise link_up_i 5 cycles after TRAIN entry -> app_ltssm_enable_o rises at cycle 9 and link_ok_o rises 4 cycles after link_up_i.
REQ-035 Hold link_up_i low -> three TRAIN attempts with retry_cnt_o 0,1,2, then link_fail_o=1 and app_ltssm_enable_o=0; dropping cfg_enable_i returns to IDLE.
REQ-036 In LINKED, pulse link_up_i low for 3 cycles -> state unchanged; hold it low for 4 cycles -> BACKOFF and drop_cnt_o=1.
REQ-037 Link-up debounce completes on the same cycle as the timeout -> LINKED, and retry_cnt_o is unchanged.
REQ-038 Assert core_rst mid-TRAIN, and separately drop cfg_enable_i mid-BACKOFF -> IDLE with outputs 0 on the next cycle.
REQ-039 In LINKED, core_clk_led_o SHALL be constantly 1; in FAILED it SHALL toggle every 8 cycles.
